// File: rtl/vae_fixed_pkg.sv
// Shared Q4.12 fixed-point definitions for the VAE latent sampling path:
// widths, saturation limits, saturating narrow function and sampler FSM states.
package vae_fixed_pkg;

  localparam int DATA_W     = 16;
  localparam int FRAC_BITS  = 12;
  localparam int LUT_ADDR_W = 6;
  localparam int SUM_W      = DATA_W + FRAC_BITS + 2;

  localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EPS  = 3'd1,
    SIG  = 3'd2,
    MUL  = 3'd3,
    HOLD = 3'd4
  } state_t;

  // Clamp a wide signed sum into the Q4.12 range.
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] s);
    if (s > SUM_W'(Q_MAX)) return Q_MAX;
    if (s < SUM_W'(Q_MIN)) return Q_MIN;
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/vae_sigma_lut.sv
// Combinational sigma = exp(logvar/2) table, addressed by logvar step index k + 32.
// Entry k holds round(exp(k/8) * 4096), clipped to 0x7FFF.
module vae_sigma_lut
  import vae_fixed_pkg::*;
(
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [DATA_W-1:0]     sigma
);

  always_comb begin
    // NOTE: assigning a default before the case keeps this purely combinational (no latch).
    sigma = 16'h7FFF;
    case (addr)
      6'd0:  sigma = 16'h004B;  6'd1:  sigma = 16'h0055;
      6'd2:  sigma = 16'h0060;  6'd3:  sigma = 16'h006D;
      6'd4:  sigma = 16'h007C;  6'd5:  sigma = 16'h008C;
      6'd6:  sigma = 16'h009F;  6'd7:  sigma = 16'h00B4;
      6'd8:  sigma = 16'h00CC;  6'd9:  sigma = 16'h00E7;
      6'd10: sigma = 16'h0106;  6'd11: sigma = 16'h0129;
      6'd12: sigma = 16'h0150;  6'd13: sigma = 16'h017D;
      6'd14: sigma = 16'h01B0;  6'd15: sigma = 16'h01E9;
      6'd16: sigma = 16'h022A;  6'd17: sigma = 16'h0274;
      6'd18: sigma = 16'h02C8;  6'd19: sigma = 16'h0327;
      6'd20: sigma = 16'h0392;  6'd21: sigma = 16'h040C;
      6'd22: sigma = 16'h0496;  6'd23: sigma = 16'h0532;
      6'd24: sigma = 16'h05E3;  6'd25: sigma = 16'h06AB;
      6'd26: sigma = 16'h078F;  6'd27: sigma = 16'h0890;
      6'd28: sigma = 16'h09B4;  6'd29: sigma = 16'h0AFF;
      6'd30: sigma = 16'h0C76;  6'd31: sigma = 16'h0E1F;
      6'd32: sigma = 16'h1000;  6'd33: sigma = 16'h1221;
      6'd34: sigma = 16'h148B;  6'd35: sigma = 16'h1748;
      6'd36: sigma = 16'h1A61;  6'd37: sigma = 16'h1DE4;
      6'd38: sigma = 16'h21DF;  6'd39: sigma = 16'h2662;
      6'd40: sigma = 16'h2B7E;  6'd41: sigma = 16'h3149;
      6'd42: sigma = 16'h37D8;  6'd43: sigma = 16'h3F48;
      6'd44: sigma = 16'h47B5;  6'd45: sigma = 16'h5141;
      6'd46: sigma = 16'h5C13;  6'd47: sigma = 16'h6855;
      6'd48: sigma = 16'h763A;
      default: sigma = 16'h7FFF;  // exp(k/8) exceeds Q4.12 range for k >= 17
    endcase
  end

endmodule

// File: rtl/vae_reparam_sampler.sv
// VAE reparameterization z = mu + exp(logvar/2) * eps, one latent element in flight,
// pulling one eps per element from the Gaussian noise generator.
module vae_reparam_sampler
  import vae_fixed_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mu,
  input  logic [DATA_W-1:0] logvar,
  input  logic              in_last,
  output logic              gauss_en,
  input  logic [DATA_W-1:0] random_number,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] z,
  output logic              out_last
);

  state_t                   state;
  logic signed [DATA_W-1:0] mu_r;
  logic signed [DATA_W-1:0] eps_r;
  logic signed [DATA_W-1:0] sigma_r;
  logic [LUT_ADDR_W-1:0]    k_r;
  logic                     last_r;
  logic [DATA_W-1:0]        lut_sigma;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum;
  logic                     unused_logvar_lsbs;

  // Bits below the 0.25 table step do not affect sigma.
  assign unused_logvar_lsbs = ^logvar[DATA_W-LUT_ADDR_W-1:0];

  // Gated by rst so no request or accept is visible while reset is held.
  assign in_ready = (state == IDLE) && rst;
  assign gauss_en = in_valid && in_ready;

  // Signed k in -32..31 maps to table address k + 32 by flipping its sign bit.
  vae_sigma_lut u_sigma_lut (
    .addr  ({~k_r[LUT_ADDR_W-1], k_r[LUT_ADDR_W-2:0]}),
    .sigma (lut_sigma)
  );

  assign prod = sigma_r * eps_r;
  assign sum  = SUM_W'(prod >>> FRAC_BITS) + SUM_W'(mu_r);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mu_r      <= '0;
      eps_r     <= '0;
      sigma_r   <= '0;
      k_r       <= '0;
      last_r    <= 1'b0;
      z         <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mu_r   <= mu;
            k_r    <= logvar[DATA_W-1 -: LUT_ADDR_W];
            last_r <= in_last;
            state  <= EPS;
          end
        end
        EPS: begin
          eps_r <= random_number;
          state <= SIG;
        end
        SIG: begin
          sigma_r <= lut_sigma;
          state   <= MUL;
        end
        MUL: begin
          z         <= saturate(sum);
          out_last  <= last_r;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vae_reparam_sampler.sv
// Self-checking bench for vae_reparam_sampler: directed and random elements against
// a real-arithmetic model of z = sat(mu + floor(round(exp(k/8)*4096) * eps / 4096)).
module tb_vae_reparam_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] mu = '0;
  logic [15:0] logvar = '0;
  logic        in_last = 1'b0;
  logic        gauss_en;
  logic [15:0] random_number = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] z;
  logic        out_last;

  logic [15:0] eps_next = '0;
  int          gauss_cnt = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          pulses_before = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  vae_reparam_sampler dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mu            (mu),
    .logvar        (logvar),
    .in_last       (in_last),
    .gauss_en      (gauss_en),
    .random_number (random_number),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .z             (z),
    .out_last      (out_last)
  );

  // Noise generator model: registered output, advances on each request.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gauss_en) begin
      random_number <= eps_next;
      gauss_cnt     <= gauss_cnt + 1;
    end
  end

  function automatic logic [15:0] z_ref(input logic [15:0] m, input logic [15:0] lv,
                                        input logic [15:0] e);
    int  li, ei, mi, k, si;
    real sg, ps, s;
    li = $signed(lv);
    ei = $signed(e);
    mi = $signed(m);
    k  = $rtoi($floor((real'(li) / 4096.0) / 0.25));
    sg = $floor($exp(real'(k) / 8.0) * 4096.0 + 0.5);
    if (sg > 32767.0) sg = 32767.0;
    ps = $floor(sg * real'(ei) / 4096.0);
    s  = ps + real'(mi);
    if (s > 32767.0)  s = 32767.0;
    if (s < -32768.0) s = -32768.0;
    si = $rtoi(s);
    return si[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [15:0] m, input logic [15:0] lv, input logic [15:0] e,
                         input logic last);
    in_valid = 1'b1;
    mu       = m;
    logvar   = lv;
    in_last  = last;
    eps_next = e;
  endtask

  // Returns at accept edge + 1.
  task automatic wait_accept(input string tag);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    pulses_before = gauss_cnt;
    @(posedge clk);
    accept_cyc = cyc;
    #1;
  endtask

  // Called at accept edge + 1; returns at the output handshake edge + 1.
  task automatic collect(input string tag, input logic [15:0] exp_z, input logic exp_last,
                         input int stall);
    int lat = 0;
    out_ready = (stall == 0);
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_z"}, 32'(z), 32'(exp_z));
    check({tag, "_out_last"}, 32'(out_last), 32'(exp_last));
    check({tag, "_gauss_pulses"}, 32'(gauss_cnt - pulses_before), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_z"}, 32'(z), 32'(exp_z));
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_stall_gauss_en"}, 32'(gauss_en), 32'd0);
    end
    if (stall > 0) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic elem(input string tag, input logic [15:0] m, input logic [15:0] lv,
                      input logic [15:0] e, input logic last, input int stall,
                      input logic [15:0] exp_z);
    @(posedge clk);
    #1;
    present(m, lv, e, last);
    wait_accept(tag);
    in_valid = 1'b0;
    collect(tag, exp_z, last, stall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] vm [4];
    logic [15:0] vl [4];
    logic [15:0] ve [4];
    logic [15:0] rm, rl, re;
    int          prev_acc;
    int          base;

    // Reset state, with a pending request that must not reach the generator.
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gauss_en", 32'(gauss_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Directed values and saturation corners.
    elem("unit_sigma", 16'h1000, 16'h0000, 16'h0C00, 1'b0, 0, 16'h1C00);
    elem("neg_eps",    16'h0000, 16'h0000, 16'hF400, 1'b0, 0, 16'hF400);
    elem("sat_pos",    16'h7000, 16'h4000, 16'h0C00, 1'b0, 0, 16'h7FFF);
    elem("sat_neg",    16'h9000, 16'h4000, 16'hF400, 1'b1, 0, 16'h8000);
    elem("k_min",      16'h0000, 16'h8000, 16'h1000, 1'b0, 0, 16'h004B);
    elem("k_max",      16'hF000, 16'h7FFF, 16'h1000, 1'b0, 0, 16'h6FFF);

    // Backpressure for 5 clocks.
    elem("backpressure", 16'h0800, 16'h0000, 16'h0400, 1'b1, 5, 16'h0C00);

    // Back-to-back vector with in_valid held high.
    for (int i = 0; i < 4; i++) begin
      vm[i] = 16'($urandom);
      vl[i] = 16'($urandom);
      ve[i] = 16'($urandom);
    end
    base     = gauss_cnt;
    prev_acc = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    present(vm[0], vl[0], ve[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_accept("vec");
      if (i > 0) check("vec_accept_spacing", 32'(accept_cyc - prev_acc), 32'd5);
      prev_acc = accept_cyc;
      if (i < 3) present(vm[i+1], vl[i+1], ve[i+1], (i + 1) == 3);
      else       in_valid = 1'b0;
      collect("vec", z_ref(vm[i], vl[i], ve[i]), i == 3, 0);
    end
    check("vec_gauss_total", 32'(gauss_cnt - base), 32'd4);

    // Reset while the element sits in SIG; the previous z is nonzero.
    @(posedge clk);
    #1;
    present(16'h0800, 16'h0000, 16'h0400, 1'b1);
    wait_accept("mid_rst");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_z", 32'(z), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    present(16'h0100, 16'h0000, 16'h0200, 1'b0);
    @(negedge clk);
    check("mid_rst_gauss_en", 32'(gauss_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_accept("after_rst");
    in_valid = 1'b0;
    collect("after_rst", 16'h0300, 1'b0, 0);

    // Random elements against the model.
    for (int i = 0; i < 16; i++) begin
      rm = 16'($urandom);
      rl = 16'($urandom);
      re = 16'($urandom);
      elem("rand", rm, rl, re, 1'($urandom), int'($urandom_range(0, 2)), z_ref(rm, rl, re));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
